// File: rtl/proc_gen.sv
// Multicycle datapath processor: IR fetched from DIN under Run, NREG registers, A/G ALU staging.
// Optional condition flags {Z,N,C} and the Flags port are built only when PROC_FLAGS_EN is defined.
module proc_gen #(
  parameter  int W    = 16,
  parameter  int NREG = 8,
  localparam int RW   = $clog2(NREG),
  localparam int IMMW = W - 4 - RW
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [W-1:0]  DIN,
  input  logic          Run,
  output logic          Done,
  output logic          Busy,
  input  logic [RW-1:0] DbgSel,
  output logic [W-1:0]  DbgData
`ifdef PROC_FLAGS_EN
  ,
  output logic [2:0]    Flags
`endif
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_e;
  typedef enum logic [2:0] {OP_MV, OP_MVT, OP_ADD, OP_SUB, OP_AND, OP_CMP, OP_RSV6, OP_RSV7} op_e;
  typedef enum logic [1:0] {BUS_REG, BUS_IMM, BUS_MVT, BUS_G} bus_src_e;

  state_e          state_q, state_d;
  logic [W-1:0]    ir_q, ir_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    g_q, g_d;
  logic [W-1:0]    regs_q [NREG];
  logic [W-1:0]    regs_d [NREG];
  logic            done;
  bus_src_e        bus_src;
  logic [RW-1:0]   bus_reg;
  logic [W-1:0]    bus;
  logic [W-1:0]    alu_out;

  op_e             op;
  logic            imm_m;
  logic [RW-1:0]   rx_idx;
  logic [RW-1:0]   ry_idx;
  logic [IMMW-1:0] imm;

  assign op     = op_e'(ir_q[W-1:W-3]);
  assign imm_m  = ir_q[W-4];
  assign rx_idx = ir_q[W-5:W-4-RW];
  assign imm    = ir_q[IMMW-1:0];
  assign ry_idx = imm[RW-1:0];

  function automatic logic signed [W-1:0] sext(input logic [IMMW-1:0] d);
    logic signed [W-1:0] r;
    r = {{(W-IMMW){d[IMMW-1]}}, d};
    return r;
  endfunction

  // Subtraction is A + ~B + 1 so the carry out doubles as not-borrow.
  function automatic logic [W-1:0] alu_res(input op_e o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      OP_ADD:         return a + b;
      OP_SUB, OP_CMP: return a + ~b + W'(1);
      OP_AND:         return a & b;
      default:        return '0;
    endcase
  endfunction

`ifdef PROC_FLAGS_EN
  logic [2:0] flags_q, flags_d;

  function automatic logic alu_carry(input op_e o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    case (o)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        return s[W];
      end
      OP_SUB, OP_CMP: begin
        s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return s[W];
      end
      default: return 1'b0;
    endcase
  endfunction

  assign Flags = flags_q;
`endif

  // Bus source select; an idle bus reads r0 so it never floats.
  always_comb begin
    bus_src = BUS_REG;
    bus_reg = '0;
    case (state_q)
      T1: begin
        case (op)
          OP_MV: begin
            if (imm_m) bus_src = BUS_IMM;
            else       bus_reg = ry_idx;
          end
          OP_MVT:                          bus_src = BUS_MVT;
          OP_ADD, OP_SUB, OP_AND, OP_CMP:  bus_reg = rx_idx;
          default: ;
        endcase
      end
      T2: begin
        if (imm_m) bus_src = BUS_IMM;
        else       bus_reg = ry_idx;
      end
      T3:      bus_src = BUS_G;
      default: ;
    endcase
  end

  always_comb begin
    case (bus_src)
      BUS_IMM: bus = sext(imm);
      BUS_MVT: bus = {imm[W/2-1:0], {(W-W/2){1'b0}}};
      BUS_G:   bus = g_q;
      default: bus = regs_q[bus_reg];
    endcase
  end

  assign alu_out = alu_res(op, a_q, bus);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    g_d     = g_q;
    regs_d  = regs_q;
    done    = 1'b0;
`ifdef PROC_FLAGS_EN
    flags_d = flags_q;
`endif
    case (state_q)
      T0: begin
        if (Run) begin
          ir_d    = DIN;
          state_d = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV, OP_MVT: begin
            regs_d[rx_idx] = bus;
            done           = 1'b1;
            state_d        = T0;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            a_d     = bus;
            state_d = T2;
          end
`ifdef PROC_FLAGS_EN
          OP_CMP: begin
            a_d     = bus;
            state_d = T2;
          end
`endif
          default: begin
            done    = 1'b1;
            state_d = T0;
          end
        endcase
      end
      T2: begin
        g_d = alu_out;
`ifdef PROC_FLAGS_EN
        flags_d = {(alu_out == '0), alu_out[W-1], alu_carry(op, a_q, bus)};
`endif
        if (op == OP_CMP) begin
          done    = 1'b1;
          state_d = T0;
        end else begin
          state_d = T3;
        end
      end
      default: begin
        regs_d[rx_idx] = bus;
        done           = 1'b1;
        state_d        = T0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
`ifdef PROC_FLAGS_EN
      flags_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      regs_q  <= regs_d;
`ifdef PROC_FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end

  assign Done    = done;
  assign Busy    = (state_q != T0);
  assign DbgData = regs_q[DbgSel];

endmodule

// File: tb/tb_proc_gen.sv
// Randomized bench for proc_gen (W=16, NREG=8) against an instruction-level reference model.
module tb_proc_gen;

  logic        clk;
  logic        Reset;
  logic [15:0] DIN;
  logic        Run;
  logic        Done;
  logic        Busy;
  logic [2:0]  DbgSel;
  logic [15:0] DbgData;
`ifdef PROC_FLAGS_EN
  logic [2:0]  Flags;
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  proc_gen #(.W(16), .NREG(8)) dut (
    .Clock   (clk),
    .Reset   (Reset),
    .DIN     (DIN),
    .Run     (Run),
    .Done    (Done),
    .Busy    (Busy),
    .DbgSel  (DbgSel),
    .DbgData (DbgData)
`ifdef PROC_FLAGS_EN
    ,
    .Flags   (Flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] mregs [8];
  logic [2:0]  mflags;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction-level model: updates architectural state, returns cycles from Run sample to Done.
  task automatic model_step(input logic [15:0] din, output int lat);
    int iii, rx, dv, a, b, full, res;
    bit m, carry;
    iii = int'(din[15:13]);
    m   = din[12];
    rx  = int'(din[11:9]);
    dv  = int'(din[8:0]);
    a   = int'(mregs[rx]);
    b   = m ? ((dv >= 256) ? dv + 65536 - 512 : dv) : int'(mregs[dv % 8]);
    lat = 2;
    res = 0;
    carry = 1'b0;
    case (iii)
      0: mregs[rx] = 16'(b);
      1: mregs[rx] = 16'((dv % 256) * 256);
      2, 3, 4: begin
        if (iii == 2) begin
          full = a + b;
          res = full % 65536;
          carry = (full > 65535);
        end else if (iii == 3) begin
          res = (a - b + 65536) % 65536;
          carry = (a >= b);
        end else begin
          res = a & b;
        end
        mregs[rx] = 16'(res);
        if (FLAGS_EN) mflags = {(res == 0), (res >= 32768), carry};
        lat = 4;
      end
      5: begin
        if (FLAGS_EN) begin
          res = (a - b + 65536) % 65536;
          mflags = {(res == 0), (res >= 32768), (a >= b)};
          lat = 3;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) begin
      DbgSel = 3'(i);
      #1;
      chk($sformatf("r%0d", i), DbgData, mregs[i]);
    end
`ifdef PROC_FLAGS_EN
    chk("flags", Flags, mflags);
`endif
    @(negedge clk);
  endtask

  task automatic dbg_read(input int idx, output logic [15:0] v);
    DbgSel = 3'(idx);
    #1;
    v = DbgData;
  endtask

  // Called at a negedge with the FSM idle in T0.
  task automatic exec(input logic [15:0] din, input bit noise);
    int lat, c;
    bit seen;
    model_step(din, lat);
    chk("t0_busy", Busy, 0);
    chk("t0_done", Done, 0);
    Run = 1'b1;
    DIN = din;
    @(posedge clk); @(negedge clk);
    Run = noise ? 1'($urandom) : 1'b0;
    DIN = noise ? 16'($urandom) : 16'h0;
    seen = 1'b0;
    c = 1;
    while (!seen && c < 8) begin
      c++;
      chk("busy", Busy, 1);
      if (Done) seen = 1'b1;
      else begin
        @(posedge clk); @(negedge clk);
        if (noise) begin
          Run = 1'($urandom);
          DIN = 16'($urandom);
        end
      end
    end
    chk($sformatf("latency_%04h", din), c, lat);
    Run = 1'b0;
    @(posedge clk); @(negedge clk);
    check_regs();
  endtask

  task automatic back_to_back(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
    logic [15:0] d [3];
    int e [3];
    int l, tot, ndone;
    d[0] = d0; d[1] = d1; d[2] = d2;
    tot = 0;
    for (int k = 0; k < 3; k++) begin
      model_step(d[k], l);
      tot += l;
      e[k] = tot;
    end
    ndone = 0;
    Run = 1'b1;
    DIN = d[0];
    for (int cyc = 1; cyc <= tot; cyc++) begin
      if (Done) begin
        chk("b2b_done_cycle", cyc, (ndone < 3) ? e[ndone] : -1);
        ndone++;
        if (ndone < 3) DIN = d[ndone];
      end
      @(posedge clk); @(negedge clk);
    end
    Run = 1'b0;
    chk("b2b_done_count", ndone, 3);
    check_regs();
  endtask

  task automatic reset_mid_add();
    Run = 1'b1;
    DIN = 16'h4202;
    @(posedge clk); @(negedge clk);
    Run = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("t2_busy", Busy, 1);
    Reset = 1'b1;
    @(posedge clk); @(negedge clk);
    Reset = 1'b0;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    for (int i = 0; i < 8; i++) begin
      DbgSel = 3'(i);
      #1;
      chk($sformatf("rst_r%0d", i), DbgData, 16'h0);
      mregs[i] = 16'h0;
    end
    mflags = 3'b000;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    mflags = 3'b000;
    Reset = 1'b1;
    Run = 1'b0;
    DIN = 16'h0;
    DbgSel = 3'd0;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    chk("init_busy", Busy, 0);
    chk("init_done", Done, 0);
    check_regs();

    exec(16'h13FF, 1'b0);
    dbg_read(1, v); chk("mv_sext", v, 16'hFFFF);
    exec(16'h34A5, 1'b0);
    dbg_read(2, v); chk("mvt", v, 16'hA500);
    exec(16'h1205, 1'b0);
    exec(16'h1407, 1'b0);
    exec(16'h4202, 1'b1);
    dbg_read(1, v); chk("add_reg", v, 16'd12);
    exec(16'h7408, 1'b0);
    dbg_read(2, v); chk("sub_imm", v, 16'hFFFF);
    exec(16'h36F0, 1'b0);
    exec(16'h56F0, 1'b0);
    dbg_read(3, v); chk("r3_setup", v, 16'hF0F0);
    exec(16'h96FF, 1'b1);
    dbg_read(3, v); chk("and_imm", v, 16'h00F0);
    exec(16'h1803, 1'b0);
    exec(16'hB803, 1'b0);
    dbg_read(4, v); chk("cmp_nowb", v, 16'd3);
`ifdef PROC_FLAGS_EN
    chk("cmp_flags", Flags, 3'b101);
`endif
    exec(16'h59FF, 1'b0);
    dbg_read(4, v); chk("add_wrap", v, 16'd2);
`ifdef PROC_FLAGS_EN
    chk("add_carry", Flags[0], 1'b1);
`endif
    exec(16'hE5A5, 1'b1);
    exec(16'hC123, 1'b0);
    exec(16'h4A0A, 1'b0);

    back_to_back(16'h1A12, 16'h4A05, 16'h3C3C);
    dbg_read(5, v); chk("b2b_r5", v, 16'h0024);
    dbg_read(6, v); chk("b2b_r6", v, 16'h3C00);
    @(negedge clk);

    reset_mid_add();

    for (int n = 0; n < 80; n++) begin
      exec(16'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
